// File: rtl/fc_frame_buffer.sv
// fc_frame_buffer: ping-pong frame collector ahead of the fully connected layer.
// Streams one pixel per beat (all channels in parallel) into one of two banks.
// A completed bank is then presented as a flat, stable frame until the consumer releases it.
module fc_frame_buffer #(
  parameter int unsigned INPUT_SIZE     = 5,
  parameter int unsigned INPUT_CHANNELS = 3,
  parameter int unsigned PX_SIZE        = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [INPUT_CHANNELS*PX_SIZE-1:0]     in_px,
  input  logic                                  in_first,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] img_out,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  frame_err
);

  localparam int unsigned NUM_PX = INPUT_SIZE * INPUT_SIZE;
  localparam int unsigned PIX_W  = INPUT_CHANNELS * PX_SIZE;
  localparam int unsigned CNT_W  = (NUM_PX > 1) ? $clog2(NUM_PX) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PX - 1);

  // Two banks; pixel k of a bank sits at flat bits [k*PIX_W +: PIX_W] (raster order)
  logic [1:0][NUM_PX-1:0][PIX_W-1:0] bank_q, bank_d;
  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0] px_cnt_q, px_cnt_d;
  logic             frame_err_q, frame_err_d;

  logic             accept;
  logic             rel;
  logic [CNT_W-1:0] wr_idx;

  // Handshake qualifiers derived from registered state only
  assign in_ready  = ~full_q[wr_sel_q];
  assign out_valid = full_q[rd_sel_q];
  assign img_out   = bank_q[rd_sel_q];
  assign frame_err = frame_err_q;
  assign accept    = in_valid & in_ready;
  assign rel       = out_valid & out_ready;

  // Next-state: write/complete on accept (with start-of-frame resync), free on release
  always_comb begin
    bank_d      = bank_q;
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    px_cnt_d    = px_cnt_q;
    frame_err_d = 1'b0;
    wr_idx      = px_cnt_q;

    if (accept) begin
      // A frame start arriving mid-frame abandons the partial frame and restarts at pixel 0
      if (in_first && (px_cnt_q != '0)) begin
        frame_err_d = 1'b1;
        wr_idx      = '0;
      end
      bank_d[wr_sel_q][wr_idx] = in_px;
      if (wr_idx == LAST_IDX) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        px_cnt_d         = '0;
      end else begin
        px_cnt_d = wr_idx + CNT_W'(1);
      end
    end

    // Read bank is always full when released, so it never collides with the write bank
    if (rel) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  // State registers with synchronous reset; reset drops partial and held frames
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q      <= '0;
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      px_cnt_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      px_cnt_q    <= px_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_fc_frame_buffer.sv
// Directed bench for fc_frame_buffer with a 2x2, 1-channel, 8-bit frame.
module tb_fc_frame_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_px;
  logic       in_first, in_valid, in_ready;
  logic [1:0][1:0][0:0][7:0] img_out;
  logic       out_valid, out_ready, frame_err;
  logic [31:0] img_flat;

  assign img_flat = img_out;

  fc_frame_buffer #(
    .INPUT_SIZE(2), .INPUT_CHANNELS(1), .PX_SIZE(8)
  ) dut (
    .clk(clk), .rst(rst), .in_px(in_px), .in_first(in_first),
    .in_valid(in_valid), .in_ready(in_ready), .img_out(img_out),
    .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err)
  );

  typedef struct {
    logic        v;
    logic        f;
    logic [7:0]  px;
    logic        ordy;
    logic        erdy;
    logic        eov;
    logic [31:0] eimg;
    logic        eerr;
  } vec_t;

  localparam int NV = 21;
  localparam logic [31:0] F1 = 32'h44332211;
  localparam logic [31:0] F2 = 32'hA4A3A2A1;
  localparam logic [31:0] F3 = 32'h88776655;

  vec_t vecs [NV];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_frame(input int f);
    logic [31:0] r;
    for (int p = 0; p < 4; p++) r[p*8 +: 8] = 8'((f << 4) | p);
    return r;
  endfunction

  // Single beat: hold it until accepted (bounded), then drop in_valid
  task automatic send_beat(input logic first, input logic [7:0] px);
    int n;
    in_valid = 1'b1;
    in_first = first;
    in_px    = px;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f_tx, p_tx, rx, cyc;

    // {valid, first, px, out_ready, exp in_ready, exp out_valid, exp img, exp frame_err}
    // Outputs are checked before the edge at which the row's inputs take effect.
    vecs[0]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h44, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, F1,    1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 1'b1, F1,    1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'hA3, 1'b0, 1'b1, 1'b1, F1,    1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'hA4, 1'b0, 1'b1, 1'b1, F1,    1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, F1,    1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, F1,    1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, F1,    1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1, F2,    1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, F2,    1'b0};
    vecs[13] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, F2,    1'b0};
    vecs[14] = '{1'b1, 1'b0, 8'h66, 1'b0, 1'b1, 1'b1, F2,    1'b1};
    vecs[15] = '{1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 1'b1, F2,    1'b0};
    vecs[16] = '{1'b1, 1'b0, 8'h88, 1'b0, 1'b1, 1'b1, F2,    1'b0};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, F2,    1'b0};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, F3,    1'b0};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, F3,    1'b0};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};

    rst = 1'b1; in_px = '0; in_first = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_img",       img_flat,       32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);

    // Fill, back-pressure, release, resync
    for (int i = 0; i < NV; i++) begin
      in_valid  = vecs[i].v;
      in_first  = vecs[i].f;
      in_px     = vecs[i].px;
      out_ready = vecs[i].ordy;
      chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].erdy));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
      chk($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].eerr));
      if (vecs[i].eov) chk($sformatf("vec%0d_img", i), img_flat, vecs[i].eimg);
      @(negedge clk);
    end

    // Streaming with out_ready high and random upstream gaps
    in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
    f_tx = 0; p_tx = 0; rx = 0; cyc = 0;
    while (rx < 10 && cyc < 2000) begin
      if (out_valid) begin
        chk($sformatf("stream_img%0d", rx), img_flat, exp_frame(rx));
        rx++;
      end
      chk("stream_frame_err", 32'(frame_err), 32'd0);
      chk("stream_in_ready",  32'(in_ready),  32'd1);
      if (f_tx < 10 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_first = (p_tx == 0);
        in_px    = 8'((f_tx << 4) | p_tx);
        if (in_ready) begin
          p_tx++;
          if (p_tx == 4) begin
            p_tx = 0;
            f_tx++;
          end
        end
      end else begin
        in_valid = 1'b0;
        in_first = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_first = 1'b0;
    chk("stream_frames_rx", 32'(rx),   32'd10);
    chk("stream_frames_tx", 32'(f_tx), 32'd10);

    // Reset mid-frame with a held frame
    out_ready = 1'b0;
    send_beat(1'b1, 8'hB1);
    send_beat(1'b0, 8'hB2);
    send_beat(1'b0, 8'hB3);
    send_beat(1'b0, 8'hB4);
    chk("held_out_valid", 32'(out_valid), 32'd1);
    chk("held_img",       img_flat,       32'hB4B3B2B1);
    send_beat(1'b1, 8'hC1);
    send_beat(1'b0, 8'hC2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_img",       img_flat,       32'h0);
    chk("midrst_frame_err", 32'(frame_err), 32'd0);
    send_beat(1'b1, 8'hD1);
    send_beat(1'b0, 8'hD2);
    send_beat(1'b0, 8'hD3);
    chk("post_rst_partial_valid", 32'(out_valid), 32'd0);
    send_beat(1'b0, 8'hD4);
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_img",       img_flat,       32'hD4D3D2D1);
    chk("post_rst_frame_err", 32'(frame_err), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("final_out_valid", 32'(out_valid), 32'd0);
    chk("final_in_ready",  32'(in_ready),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
